// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between the fetch unit (req0)
// and the bitty core (req1). Each requester owns a one-byte holding slot.
// The grant FSM launches one byte at a time, waits for tx_done (or a watchdog
// timeout), and returns a done pulse to the owning requester.
// Build option: define UART_ARB_RR_EN for round-robin tie breaking; without it
// requester 0 wins every tie (fixed priority).
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 60000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_start,
    input  logic [7:0] req0_data,
    output logic       req0_busy,
    output logic       req0_done,
    input  logic       req1_start,
    input  logic [7:0] req1_data,
    output logic       req1_busy,
    output logic       req1_done,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       arb_owner,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RELEASE
    } state_t;

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        slot0_full;
    logic        slot1_full;
    logic [7:0]  slot0_data;
    logic [7:0]  slot1_data;
    logic [15:0] count;
    logic        owner;
    logic [7:0]  tx_data_q;
    logic        timeout_q;
    logic        grant;
    logic        timeout_hit;

    // Pick which full slot to serve next; only meaningful when a slot is full.
    always_comb begin
        grant = 1'b0;
`ifdef UART_ARB_RR_EN
        if (slot0_full && slot1_full) begin
            grant = ~owner;
        end else begin
            grant = slot1_full;
        end
`else
        grant = ~slot0_full;
`endif
    end

    // Next-state logic and the watchdog decision; tx_done wins over timeout.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (slot0_full || slot1_full) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_next = RELEASE;
                end else if (count == LIMIT) begin
                    timeout_hit = 1'b1;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, grant registers, watchdog counter and sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            tx_data_q <= 8'd0;
            count     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && (slot0_full || slot1_full)) begin
                owner     <= grant;
                tx_data_q <= grant ? slot1_data : slot0_data;
            end
            if (state == LAUNCH) begin
                count <= 16'd0;
            end else if (state == WAIT_DONE) begin
                count <= count + 16'd1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Holding slots: capture only into an empty slot, free on the owner's release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slot0_full <= 1'b0;
            slot1_full <= 1'b0;
            slot0_data <= 8'd0;
            slot1_data <= 8'd0;
        end else begin
            if (state == RELEASE && owner == 1'b0) begin
                slot0_full <= 1'b0;
            end else if (req0_start && !slot0_full) begin
                slot0_full <= 1'b1;
                slot0_data <= req0_data;
            end
            if (state == RELEASE && owner == 1'b1) begin
                slot1_full <= 1'b0;
            end else if (req1_start && !slot1_full) begin
                slot1_full <= 1'b1;
                slot1_data <= req1_data;
            end
        end
    end

    // Outputs decode directly from registered state, so none depend on inputs.
    always_comb begin
        tx_en       = (state == LAUNCH);
        tx_data     = tx_data_q;
        arb_owner   = owner;
        timeout_err = timeout_q;
        req0_busy   = slot0_full;
        req1_busy   = slot1_full;
        req0_done   = (state == RELEASE) && (owner == 1'b0);
        req1_done   = (state == RELEASE) && (owner == 1'b1);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Expected {owner, byte} pairs are queued
// when a byte is offered and compared whenever the arbiter pulses tx_en.
// A second instance with a short watchdog covers the timeout behaviour.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_start = 1'b0;
    logic       req1_start = 1'b0;
    logic [7:0] req0_data = 8'd0;
    logic [7:0] req1_data = 8'd0;
    logic       tx_done = 1'b0;

    logic       req0_busy, req0_done, req1_busy, req1_done, tx_en, arb_owner, timeout_err;
    logic [7:0] tx_data;
    logic       t_req0_busy, t_req0_done, t_req1_busy, t_req1_done, t_tx_en, t_arb_owner, t_timeout_err;
    logic [7:0] t_tx_data;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .req0_start(req0_start), .req0_data(req0_data), .req0_busy(req0_busy), .req0_done(req0_done),
        .req1_start(req1_start), .req1_data(req1_data), .req1_busy(req1_busy), .req1_done(req1_done),
        .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done),
        .arb_owner(arb_owner), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .reset(reset),
        .req0_start(req0_start), .req0_data(req0_data), .req0_busy(t_req0_busy), .req0_done(t_req0_done),
        .req1_start(req1_start), .req1_data(req1_data), .req1_busy(t_req1_busy), .req1_done(t_req1_done),
        .tx_en(t_tx_en), .tx_data(t_tx_data), .tx_done(tx_done),
        .arb_owner(t_arb_owner), .timeout_err(t_timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int en_count = 0, en_cyc = 0, done0_count = 0, done1_count = 0;
    int to_en_count = 0, to_en_cyc = 0;
    bit mon_main = 1'b1;
    bit mon_to = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_to_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (mon_main && reset) begin
            if (tx_en) begin
                en_count++;
                en_cyc = cyc;
                checkOutput("scoreboard_has_entry", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) checkOutput("tx_owner_byte", 32'({arb_owner, tx_data}), 32'(exp_q.pop_front()));
            end
            if (req0_done) done0_count++;
            if (req1_done) done1_count++;
        end
    end

    // Scoreboard monitor for the short-watchdog instance.
    always @(negedge clk) begin
        if (mon_to && reset && t_tx_en) begin
            to_en_count++;
            to_en_cyc = cyc;
            checkOutput("to_scoreboard_has_entry", int'(exp_to_q.size() > 0), 1);
            if (exp_to_q.size() > 0) checkOutput("to_tx_owner_byte", 32'({t_arb_owner, t_tx_data}), 32'(exp_to_q.pop_front()));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyReset();
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        exp_to_q.delete();
        reset = 1'b0;
        req0_start = 1'b0;
        req1_start = 1'b0;
        tx_done = 1'b0;
        step(2);
        reset = 1'b1;
        en_count = 0;
        done0_count = 0;
        done1_count = 0;
        to_en_count = 0;
    endtask

    task automatic applyStimulus(input bit which, input logic [7:0] data);
        if (which) begin
            req1_start = 1'b1;
            req1_data = data;
        end else begin
            req0_start = 1'b1;
            req0_data = data;
        end
        step(1);
        req0_start = 1'b0;
        req1_start = 1'b0;
    endtask

    task automatic waitEn(input bit to, input int prev, output int at);
        int cnt;
        cnt = to ? to_en_count : en_count;
        for (int i = 0; i < 200 && cnt == prev; i++) begin
            step(1);
            cnt = to ? to_en_count : en_count;
        end
        if (cnt == prev) checkOutput("tx_en_wait", cnt, prev + 1);
        at = to ? to_en_cyc : en_cyc;
    endtask

    task automatic pulseDone(input int at);
        while (cyc < at) step(1);
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int s, l0, l1;

        // Test 1: single byte latency and completion timing.
        applyReset();
        checkOutput("reset_outputs", 32'({tx_en, tx_data, req0_busy, req1_busy, req0_done, req1_done, arb_owner, timeout_err}), 0);
        step(8);
        s = cyc;
        exp_q.push_back({1'b0, 8'h41});
        applyStimulus(1'b0, 8'h41);
        checkOutput("t1_req0_busy_after_start", req0_busy, 1);
        waitEn(1'b0, 0, l0);
        checkOutput("t1_launch_latency", l0 - s, 2);
        pulseDone(l0 + 28);
        checkOutput("t1_req0_done", req0_done, 1);
        checkOutput("t1_req0_busy_in_release", req0_busy, 1);
        step(1);
        checkOutput("t1_req0_busy_cleared", req0_busy, 0);
        checkOutput("t1_req0_done_one_cycle", req0_done, 0);
        step(3);
        checkOutput("t1_single_tx_en", en_count, 1);

        // Test 2: simultaneous requests, order depends on the build.
        applyReset();
        step(2);
`ifdef UART_ARB_RR_EN
        exp_q.push_back({1'b1, 8'hAA});
        exp_q.push_back({1'b0, 8'h55});
`else
        exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b1, 8'hAA});
`endif
        req0_start = 1'b1;
        req0_data = 8'h55;
        req1_start = 1'b1;
        req1_data = 8'hAA;
        step(1);
        req0_start = 1'b0;
        req1_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            waitEn(1'b0, k, l0);
            pulseDone(l0 + 20);
        end
        step(5);
        checkOutput("t2_two_tx_en", en_count, 2);
        checkOutput("t2_done0_count", done0_count, 1);
        checkOutput("t2_done1_count", done1_count, 1);

        // Test 3: a second start while the slot is busy is dropped.
        applyReset();
        exp_q.push_back({1'b0, 8'h11});
        applyStimulus(1'b0, 8'h11);
        waitEn(1'b0, 0, l0);
        exp_q.push_back({1'b1, 8'h12});
        applyStimulus(1'b1, 8'h12);
        checkOutput("t3_req1_busy", req1_busy, 1);
        applyStimulus(1'b1, 8'h34);
        pulseDone(l0 + 10);
        waitEn(1'b0, 1, l1);
        pulseDone(l1 + 10);
        step(4);
        checkOutput("t3_tx_en_count", en_count, 2);
        checkOutput("t3_done1_single", done1_count, 1);
        checkOutput("t3_req1_busy_cleared", req1_busy, 0);

        // Test 4: watchdog abort on the short-timeout instance.
        mon_main = 1'b0;
        mon_to = 1'b1;
        applyReset();
        exp_to_q.push_back({1'b0, 8'h7E});
        applyStimulus(1'b0, 8'h7E);
        waitEn(1'b1, 0, l0);
        while (cyc < l0 + 16) step(1);
        checkOutput("t4_no_done_while_waiting", t_req0_done, 0);
        step(1);
        checkOutput("t4_timeout_err_set", t_timeout_err, 1);
        checkOutput("t4_req0_done_on_abort", t_req0_done, 1);
        step(1);
        checkOutput("t4_req0_busy_cleared", t_req0_busy, 0);
        exp_to_q.push_back({1'b1, 8'h01});
        applyStimulus(1'b1, 8'h01);
        waitEn(1'b1, 1, l1);
        pulseDone(l1 + 5);
        checkOutput("t4_req1_done_after_abort", t_req1_done, 1);
        checkOutput("t4_timeout_err_sticky", t_timeout_err, 1);
        checkOutput("t4_to_drained", exp_to_q.size(), 0);
        mon_to = 1'b0;
        mon_main = 1'b1;

        // Test 5: spurious tx_done in IDLE, then reset in WAIT_DONE.
        applyReset();
        step(2);
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
        checkOutput("t5_no_done_on_spurious", 32'({req0_done, req1_done}), 0);
        step(2);
        checkOutput("t5_no_launch_on_spurious", en_count, 0);
        exp_q.push_back({1'b0, 8'h33});
        applyStimulus(1'b0, 8'h33);
        waitEn(1'b0, 0, l0);
        step(2);
        checkOutput("t5_tx_data_in_wait", tx_data, 8'h33);
        reset = 1'b0;
        step(1);
        checkOutput("t5_reset_outputs", 32'({tx_en, tx_data, req0_busy, req1_busy, req0_done, req1_done, arb_owner, timeout_err}), 0);
        reset = 1'b1;
        step(6);
        checkOutput("t5_no_done_after_reset", done0_count, 0);
        checkOutput("t5_no_relaunch", en_count, 1);

        // Test 6: back-to-back grant three cycles after tx_done.
        applyReset();
        exp_q.push_back({1'b0, 8'h40});
        applyStimulus(1'b0, 8'h40);
        waitEn(1'b0, 0, l0);
        while (cyc < l0 + 3) step(1);
        exp_q.push_back({1'b1, 8'h20});
        applyStimulus(1'b1, 8'h20);
        pulseDone(l0 + 10);
        waitEn(1'b0, 1, l1);
        checkOutput("t6_back_to_back_gap", l1 - (l0 + 10), 3);
        pulseDone(l1 + 5);
        step(3);
        checkOutput("t6_done1_count", done1_count, 1);
        checkOutput("t6_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between two byte producers: requester 0 (instruction fetch unit) and requester 1 (bitty core). Each requester has a one-byte holding slot. A grant FSM launches one byte at a time into the UART, holds ownership until the UART reports tx_done, and returns a completion pulse to the owner. This replaces the top-level select-driven tx_en/tx_data muxing. A watchdog aborts a transfer that never completes.

Parameters:
TIMEOUT_CYCLES, 60000, cycles spent in WAIT_DONE before abort. Range 1..65535; 16-bit counter. Default exceeds one 9600-baud frame (10 x 5208).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req0_start  in  1  one-cycle pulse; byte on req0_data offered by fetch unit
req0_data  in  8  byte from fetch unit, sampled with req0_start
req0_busy  out  1  requester 0 slot occupied or in service
req0_done  out  1  one-cycle pulse; requester 0 byte finished (or aborted)
req1_start  in  1  one-cycle pulse; byte from bitty core
req1_data  in  8  byte from bitty core
req1_busy  out  1  requester 1 slot occupied or in service
req1_done  out  1  one-cycle pulse; requester 1 byte finished (or aborted)
tx_en  out  1  one-cycle start pulse to UART transmitter
tx_data  out  8  byte to UART, stable from LAUNCH through WAIT_DONE
tx_done  in  1  UART transmit-complete pulse
arb_owner  out  1  current/last granted requester (0 or 1)
timeout_err  out  1  sticky; set on watchdog abort

Behaviour:
- Reset (reset==0 at clk edge):
  - FSM to IDLE; both slots empty; counter 0.
  - tx_en=0, tx_data=0, reqN_busy=0, reqN_done=0, arb_owner=0, timeout_err=0.
- Slot capture:
  - reqN_start with slot empty: latch reqN_data and set slot full on that edge; reqN_busy=1 from the next cycle.
  - reqN_start while reqN_busy=1 is ignored. The slot byte is not overwritten.
- FSM states: IDLE, LAUNCH, WAIT_DONE, RELEASE.
  - IDLE: if any slot is full, select the owner per policy, register arb_owner and tx_data from that slot, go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: tx_en=1 for exactly this cycle; clear counter; go to WAIT_DONE.
  - WAIT_DONE: counter increments each cycle.
    - tx_done=1: go to RELEASE.
    - Otherwise, counter reaching TIMEOUT_CYCLES-1: set timeout_err, go to RELEASE.
  - RELEASE: pulse req{arb_owner}_done for one cycle; clear that slot; go to IDLE. busy drops the cycle after RELEASE.
- Latency:
  - start at cycle t into an idle arbiter: tx_en high at t+2.
  - tx_done at cycle d: done pulse at d+1.
  - Next byte's tx_en no earlier than d+3.
- tx_done seen in IDLE, LAUNCH or RELEASE is ignored.
- reqN_start in the same cycle as its own RELEASE is ignored (busy still 1).
- Start from one requester while the other is being serviced is captured normally. It is granted at the next IDLE.
- Default policy (macro absent): fixed priority, requester 0 (fetch) wins when both slots are full in IDLE.
- tx_data holds its last value in IDLE and RELEASE. Only the LAUNCH cycle qualifies it (via tx_en).
- Reset mid-transfer: everything returns to reset values on that edge; no done pulse is generated.
- timeout_err clears only on reset.

Optional Feature:
UART_ARB_RR_EN
- Defined: round-robin grant. When both slots are full in IDLE, grant the requester that is not arb_owner (last served). A single pending requester is always granted. After reset arb_owner=0, so requester 1 wins the first tie.
- Undefined: fixed priority, requester 0 always wins ties.
- Single-requester behaviour and timing are identical in both builds.

Test Plan:
1. Reset, req0_start with data 0x41 at cycle 10 -> tx_en=1 only at cycle 12 with tx_data=0x41, arb_owner=0; tx_done at 40 -> req0_done at 41, req0_busy=0 at 42.
2. req0_start 0x55 and req1_start 0xAA in the same cycle, tx_done returned 20 cycles after each tx_en:
   - Default build: bytes go out 0x55 then 0xAA.
   - UART_ARB_RR_EN build: 0xAA then 0x55.
   - Exactly two tx_en pulses either way.
3. req1_start 0x12, then req1_start 0x34 while req1_busy=1 -> only 0x12 transmitted, slot unchanged, single req1_done.
4. TIMEOUT_CYCLES=16, req0_start 0x7E, tx_done never asserted -> timeout_err=1 on the 16th WAIT_DONE cycle. Then req0_done pulses and the FSM returns to IDLE. A following req1_start 0x01 still transmits.
5. Spurious tx_done while IDLE -> no done pulse, no state change. reset=0 asserted during WAIT_DONE -> all outputs at reset values next cycle, no done pulse, slots empty.
6. Back-to-back: req1_start 0x20 issued during requester 0's WAIT_DONE -> req1 tx_en exactly 3 cycles after req0's tx_done, tx_data=0x20, arb_owner=1.
